// File: rtl/demux_2_pkg.sv
// Shared constants and types for the 1:2 buffered key demultiplexer.
// Optional push statistics are enabled with macro DEMUX_2_STATS_EN.
package demux_2_pkg;

  localparam int DEMUX_WIDTH = 20;
  localparam int DEMUX_DEPTH = 2;
  localparam int PTR_W       = $clog2(DEMUX_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int STATS_W     = 16;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_t;

endpackage

// File: rtl/demux_fifo.sv
// Single-clock FIFO: push/pop/flush, head word forced to zero when empty.
// Ports: clk, rst_n, flush_i, push_i, data_i, pop_i -> valid_o, full_o, data_o.
module demux_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  // Flush overrides both push and pop.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & valid_o & ~flush_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/demux_2_buf.sv
// 1:2 buffered demux: steers one valid/ready key stream into two FIFOs.
// Ports: in_* stream, y0_*/y1_* sinks, flush; cnt0/cnt1 with DEMUX_2_STATS_EN.
module demux_2_buf
  import demux_2_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic               y0_valid,
  input  logic               y0_ready,
  output logic [WIDTH-1:0]   y0_data,
  output logic               y1_valid,
  input  logic               y1_ready,
  output logic [WIDTH-1:0]   y1_data
`ifdef DEMUX_2_STATS_EN
  ,
  output logic [STATS_W-1:0] cnt0,
  output logic [STATS_W-1:0] cnt1
`endif
);

  chan_t      sel_c;
  logic [1:0] full;
  logic [1:0] push;

  assign sel_c = chan_t'(in_sel);

  // Ready only looks at registered fullness: no pass-through when full.
  assign in_ready = rst_n & ~flush &
                    ~((sel_c == CH1) ? full[1] : full[0]);

  assign push[0] = in_valid & in_ready & (sel_c == CH0);
  assign push[1] = in_valid & in_ready & (sel_c == CH1);

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push[0]),
    .data_i  (in_data),
    .pop_i   (y0_ready),
    .valid_o (y0_valid),
    .full_o  (full[0]),
    .data_o  (y0_data)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push[1]),
    .data_i  (in_data),
    .pop_i   (y1_ready),
    .valid_o (y1_valid),
    .full_o  (full[1]),
    .data_o  (y1_data)
  );

`ifdef DEMUX_2_STATS_EN
  logic [STATS_W-1:0] cnt0_q, cnt0_d;
  logic [STATS_W-1:0] cnt1_q, cnt1_d;

  // Flush does not clear the statistics; they wrap naturally.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (push[0]) cnt0_d = cnt0_q + STATS_W'(1);
    if (push[1]) cnt1_d = cnt1_q + STATS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_2_buf.sv
// Bench for demux_2_buf: queue model plus directed literal checks.
// Stats checks are compiled in with DEMUX_2_STATS_EN.
module tb_demux_2_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [19:0] in_data;
  logic        y0_valid, y0_ready;
  logic [19:0] y0_data;
  logic        y1_valid, y1_ready;
  logic [19:0] y1_data;
`ifdef DEMUX_2_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  demux_2_buf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y0_data  (y0_data),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .y1_data  (y1_data)
`ifdef DEMUX_2_STATS_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: two bounded queues of depth 2, plus push counters.
  logic [19:0] q0[$];
  logic [19:0] q1[$];
  logic [15:0] mc0 = '0;
  logic [15:0] mc1 = '0;

  always @(posedge clk or negedge rst_n) begin : model
    bit acc, p0, p1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      mc0 = '0;
      mc1 = '0;
    end else if (flush) begin
      q0.delete();
      q1.delete();
    end else begin
      acc = in_valid &&
            ((in_sel ? q1.size() : q0.size()) < 2);
      p0 = y0_ready && (q0.size() > 0);
      p1 = y1_ready && (q1.size() > 0);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (in_sel) begin
          q1.push_back(in_data);
          mc1 = mc1 + 16'd1;
        end else begin
          q0.push_back(in_data);
          mc0 = mc0 + 16'd1;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin : cmp
    logic er;
    er = rst_n && !flush &&
         ((in_sel ? q1.size() : q0.size()) < 2);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("y0_valid", 32'(y0_valid), 32'(q0.size() != 0));
    chk("y1_valid", 32'(y1_valid), 32'(q1.size() != 0));
    chk("y0_data", 32'(y0_data),
        32'((q0.size() != 0) ? q0[0] : 20'h0));
    chk("y1_data", 32'(y1_data),
        32'((q1.size() != 0) ? q1[0] : 20'h0));
`ifdef DEMUX_2_STATS_EN
    chk("cnt0", 32'(cnt0), 32'(mc0));
    chk("cnt1", 32'(cnt1), 32'(mc1));
`endif
  end

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic drv(logic v, logic s, logic [19:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    drv(1'b1, 1'b0, 20'h55555);

    // 1 reset
    nxt();
    nxt();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_y0_valid", 32'(y0_valid), 32'd0);
    chk("rst_y1_valid", 32'(y1_valid), 32'd0);
    chk("rst_y0_data", 32'(y0_data), 32'd0);
    chk("rst_y1_data", 32'(y1_data), 32'd0);
    drv(1'b0, 1'b0, 20'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // 2 routing
    drv(1'b1, 1'b0, 20'h12345);
    nxt();
    chk("rt_y0_data", 32'(y0_data), 32'h12345);
    chk("rt_y1_valid", 32'(y1_valid), 32'd0);
    drv(1'b1, 1'b1, 20'hABCDE);
    nxt();
    chk("rt_y1_data", 32'(y1_data), 32'hABCDE);
    chk("rt_y0_gone", 32'(y0_valid), 32'd0);
    drv(1'b0, 1'b0, 20'h0);
    nxt();
    chk("rt_y1_gone", 32'(y1_valid), 32'd0);

    // 3 fill / stall
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    drv(1'b1, 1'b0, 20'hA0001);
    nxt();
    drv(1'b1, 1'b0, 20'hA0002);
    nxt();
    chk("full_ready", 32'(in_ready), 32'd0);
    drv(1'b1, 1'b0, 20'hA0003);
    nxt();
    chk("full_head", 32'(y0_data), 32'hA0001);
    drv(1'b1, 1'b1, 20'hB0001);
    #1;
    chk("other_ready", 32'(in_ready), 32'd1);
    nxt();
    chk("other_data", 32'(y1_data), 32'hB0001);
    drv(1'b0, 1'b0, 20'h0);
    y0_ready = 1'b1;
    nxt();
    chk("drain_2nd", 32'(y0_data), 32'hA0002);
    nxt();
    chk("drain_empty", 32'(y0_valid), 32'd0);
    y1_ready = 1'b1;
    nxt();

    // 4 push+pop at count 1
    for (int i = 1; i <= 8; i++) begin
      drv(1'b1, 1'b0, 20'(i));
      nxt();
      chk("pp_head", 32'(y0_data), 32'(i));
    end
    drv(1'b0, 1'b0, 20'h0);
    nxt();

    // 5 flush with both full, then wrap
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    drv(1'b1, 1'b0, 20'hC0001); nxt();
    drv(1'b1, 1'b0, 20'hC0002); nxt();
    drv(1'b1, 1'b1, 20'hD0001); nxt();
    drv(1'b1, 1'b1, 20'hD0002); nxt();
    flush = 1'b1;
    y0_ready = 1'b1;
    drv(1'b1, 1'b0, 20'hEEEEE);
    nxt();
    chk("fl_y0_valid", 32'(y0_valid), 32'd0);
    chk("fl_y1_valid", 32'(y1_valid), 32'd0);
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      y0_ready = i[0];
      drv(1'b1, 1'b0, 20'h50000 + 20'(i));
      nxt();
    end
    drv(1'b0, 1'b0, 20'h0);
    y0_ready = 1'b1;
    nxt();
    nxt();
    chk("wrap_empty", 32'(y0_valid), 32'd0);

    // reset mid-transfer
    y1_ready = 1'b0;
    drv(1'b1, 1'b1, 20'hF0001);
    nxt();
    nxt();
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("mid_y1_valid", 32'(y1_valid), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    drv(1'b0, 1'b0, 20'h0);
    nxt();
    rst_n = 1'b1;
    y1_ready = 1'b1;
    nxt();
    chk("post_rst_y1", 32'(y1_valid), 32'd0);

`ifdef DEMUX_2_STATS_EN
    // 6 stats wrap, flush keeps, reset clears
    for (int i = 0; i < 65537; i++) begin
      drv(1'b1, 1'b1, 20'(i));
      nxt();
    end
    drv(1'b0, 1'b0, 20'h0);
    chk("st_cnt1_wrap", 32'(cnt1), 32'd1);
    chk("st_cnt0", 32'(cnt0), 32'd0);
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    chk("st_flush_keep", 32'(cnt1), 32'd1);
    drv(1'b1, 1'b0, 20'h00777);
    nxt();
    nxt();
    chk("st_cnt0_2", 32'(cnt0), 32'd2);
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("st_rst_cnt0", 32'(cnt0), 32'd0);
    chk("st_rst_cnt1", 32'(cnt1), 32'd0);
    drv(1'b0, 1'b0, 20'h0);
    nxt();
    rst_n = 1'b1;
    nxt();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
